// File: rtl/tmds_decoder.sv
// One TMDS receive lane: finds the 10-bit word boundary from DVI control tokens,
// then decodes video bytes or control values with a fixed 3-cycle latency.
module tmds_decoder #(
    parameter int LOCK_COUNT    = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int MAX_GAP       = 2048
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       ve_out,
    output logic       locked_out,
    output logic [3:0] offset_out
);
    localparam logic [15:0] MATCH_LAST = 16'(LOCK_COUNT - 1);
    localparam logic [15:0] DWELL_LAST = 16'(SEARCH_WINDOW - 1);
    localparam logic [15:0] GAP_LAST   = 16'(MAX_GAP - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state;
    logic [9:0]  prev_q;
    logic [9:0]  aligned_q;
    logic [19:0] cat;
    logic [9:0]  aligned;
    logic [15:0] dwell;
    logic [15:0] match_cnt;
    logic [15:0] gap;
    logic [1:0]  flush;
    logic        tok_hit;
    logic        tok;
    logic [1:0]  tok_val;
    logic [7:0]  d;
    logic [7:0]  dec;

    // Older word sits in the low half, so offset k takes 10-k bits of the previous word.
    assign cat     = {tmds_in, prev_q};
    assign aligned = 10'(cat >> offset_out);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prev_q    <= 10'd0;
            aligned_q <= 10'd0;
        end else begin
            prev_q    <= tmds_in;
            aligned_q <= aligned;
        end
    end

    always_comb begin
        tok_hit = 1'b1;
        tok_val = 2'b00;
        case (aligned_q)
            10'h354: tok_val = 2'b00;
            10'h0AB: tok_val = 2'b01;
            10'h154: tok_val = 2'b10;
            10'h2AB: tok_val = 2'b11;
            default: tok_hit = 1'b0;
        endcase
    end

    // aligned_q still carries old-offset bits right after a slip, so ignore it briefly.
    assign tok = tok_hit && (flush == 2'd0);

    always_comb begin
        d      = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
        dec    = 8'd0;
        dec[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = aligned_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= SEARCH;
            offset_out  <= 4'd0;
            dwell       <= 16'd0;
            match_cnt   <= 16'd0;
            gap         <= 16'd0;
            flush       <= 2'd0;
            data_out    <= 8'd0;
            control_out <= 2'b00;
            ve_out      <= 1'b0;
            locked_out  <= 1'b0;
        end else begin
            flush      <= (flush != 2'd0) ? flush - 2'd1 : 2'd0;
            locked_out <= (state == LOCKED);

            if (state == LOCKED) begin
                if (tok) begin
                    ve_out      <= 1'b0;
                    control_out <= tok_val;
                    data_out    <= 8'd0;
                end else begin
                    ve_out   <= 1'b1;
                    data_out <= dec;
                end
            end else begin
                ve_out      <= 1'b0;
                data_out    <= 8'd0;
                control_out <= 2'b00;
            end

            case (state)
                SEARCH: begin
                    if (tok) begin
                        state     <= VERIFY;
                        match_cnt <= 16'd1;
                    end else if (dwell == DWELL_LAST) begin
                        offset_out <= (offset_out == 4'd9) ? 4'd0 : offset_out + 4'd1;
                        dwell      <= 16'd0;
                        flush      <= 2'd2;
                    end else begin
                        dwell <= dwell + 16'd1;
                    end
                end
                VERIFY: begin
                    if (tok) begin
                        if (match_cnt == MATCH_LAST) begin
                            state <= LOCKED;
                            gap   <= 16'd0;
                        end else begin
                            match_cnt <= match_cnt + 16'd1;
                        end
                    end else begin
                        state <= SEARCH;
                        dwell <= 16'd0;
                    end
                end
                LOCKED: begin
                    if (tok) begin
                        gap <= 16'd0;
                    end else if (gap == GAP_LAST) begin
                        state <= SEARCH;
                        dwell <= 16'd0;
                    end else begin
                        gap <= gap + 16'd1;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end
endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
- Receive-side counterpart of tmds_encoder: one TMDS lane, fed one 10-bit deserialized word per clock, word boundary arbitrary.
- Finds the word boundary from DVI control tokens, locks, then decodes to 8-bit video data or a 2-bit control value plus a video-enable flag.
- Used in HDMI loopback/self-check of the display path, one instance per lane.

Parameters:
- LOCK_COUNT, 8, consecutive control tokens at one offset required to declare lock.
- SEARCH_WINDOW, 2048, cycles spent at one bit offset without any token before advancing the offset.
- MAX_GAP, 2048, cycles allowed in LOCKED without a control token before lock is dropped (exceeds the 1650-clock 720p line).

Ports:
- clk_in  input  1  pixel clock; one TMDS word per cycle.
- rst_in  input  1  asynchronous, active-low reset.
- tmds_in  input  10  raw deserialized word; bit 0 is first on the wire.
- data_out  output  8  decoded video byte.
- control_out  output  2  decoded control value {c1,c0} (blue lane: {vsync,hsync}).
- ve_out  output  1  1 = data_out valid video; 0 = control period or unlocked.
- locked_out  output  1  boundary lock achieved.
- offset_out  output  4  current bit-slip offset, 0..9.

Behaviour:
- Reset (rst_in low, async): all outputs 0, prev_q 0, offset 0, counters 0, state SEARCH. Takes effect mid-operation immediately; no partial lock survives.
- Alignment: prev_q <= tmds_in each cycle. cat = {tmds_in, prev_q} (20 b). aligned = cat[offset+9 : offset], registered into aligned_q.
- Decode is registered from aligned_q. Fixed latency 3 cycles: a word presented in cycle t (offset 0) drives outputs in cycle t+3.
- Token match on aligned_q (10-bit values):
  - 0x354 -> 00
  - 0x0AB -> 01
  - 0x154 -> 10
  - 0x2AB -> 11
- Data decode: d = q[9] ? ~q[7:0] : q[7:0].
  - out[0] = d[0].
  - For i = 1..7: out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- State SEARCH:
  - Dwell counter increments each cycle.
  - Token seen -> VERIFY, match count = 1.
  - Dwell reaches SEARCH_WINDOW-1 with no token -> offset+1 (9 wraps to 0), dwell = 0.
- State VERIFY:
  - Token -> count+1; count reaches LOCK_COUNT -> LOCKED, gap counter = 0.
  - Non-token -> SEARCH with offset unchanged, dwell = 0.
- State LOCKED:
  - Token -> gap = 0.
  - Otherwise gap+1; gap reaches MAX_GAP -> SEARCH, dwell = 0, offset unchanged.
  - Offset never changes while LOCKED.
- Pipeline flush on offset change: aligned_q contents for 2 cycles after an offset increment are treated as non-token.
- Outputs while LOCKED:
  - Token cycle: ve_out = 0, control_out = token value, data_out = 0.
  - Data cycle: ve_out = 1, data_out = decoded, control_out holds its last value.
- Outputs while not LOCKED: ve_out = 0, data_out = 0, control_out = 0.
- locked_out is the registered state==LOCKED, aligned in time with the first decoded output.
- Data words whose bit pattern equals a token are treated as tokens; the encoder never emits such words.

Test Plan:
- Aligned stream: 16 x 0x354 then 0x100 repeated -> locked_out rises exactly 8 tokens (+3 latency) after the first token; offset_out = 0; then ve_out = 1, data_out = 0x00.
- Data decode checks while locked: 0x2FF -> data_out 0xFE; 0x100 -> 0x00; tokens 0x0AB / 0x154 / 0x2AB -> ve_out 0, control_out 01 / 10 / 11.
- Stream rotated so the boundary sits 3 bits later (blanking 370 tokens + data per line) -> offset steps 0,1,2,3; locks at offset_out = 3; data decodes correctly.
- Locked, then 3000 consecutive data words with no token -> locked_out falls after exactly MAX_GAP = 2048 words; ve_out and data_out go to 0; offset_out retained.
- VERIFY abort: 5 tokens then one data word then tokens -> returns to SEARCH; lock only after 8 fresh consecutive tokens; offset unchanged.
- rst_in pulsed low mid-LOCKED, asynchronous to clk_in -> all outputs 0 immediately; after release, relock takes the full LOCK_COUNT sequence from offset 0.
